// File: rtl/rsi_delta_accum.sv
// rsi_delta_accum
//   Pops prices from the upstream price FIFO, forms the close-to-close delta
//   against the previous price, splits it into gain / loss magnitudes and keeps
//   running sums of both over a sliding window of PERIOD deltas. The sums are
//   offered to the RSI ratio stage through a valid/ready handshake.
//
//   Optional feature macro: RSI_PARTIAL_OUT_EN
//     defined   : sums are emitted after every update, including warm-up.
//     undefined : sums are emitted only once the window is full.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   fifo_empty   in   FIFO empty flag
//   fifo_dout    in   FIFO read data, valid the cycle after a granted read
//   fifo_rd_en   out  FIFO pop request (combinational: FETCH && !fifo_empty)
//   out_ready    in   downstream accepts the current sums
//   out_valid    out  gain_sum / loss_sum / window_full valid
//   gain_sum     out  sum of gains over the window
//   loss_sum     out  sum of loss magnitudes over the window
//   window_full  out  PERIOD deltas have been accumulated
module rsi_delta_accum #(
    parameter int WIDTH     = 16,
    parameter int PERIOD    = 14,
    parameter int SUM_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_rd_en,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [SUM_WIDTH-1:0] gain_sum,
    output logic [SUM_WIDTH-1:0] loss_sum,
    output logic                 window_full
);

    localparam int IDX_W = $clog2(PERIOD);
    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PERIOD);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   primed_r;
    logic [WIDTH-1:0]       prev_r;
    logic [WIDTH-1:0]       gain_r;
    logic [WIDTH-1:0]       loss_r;
    logic [IDX_W-1:0]       idx_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_inc_s;
    logic [SUM_WIDTH-1:0]   gain_sum_r;
    logic [SUM_WIDTH-1:0]   loss_sum_r;
    logic                   window_full_r;
    logic                   out_valid_r;
    logic [WIDTH-1:0]       gbuf_r [PERIOD];
    logic [WIDTH-1:0]       lbuf_r [PERIOD];

    logic [WIDTH:0]         delta_s;
    logic [WIDTH-1:0]       neg_delta_s;
    logic [WIDTH-1:0]       gain_s;
    logic [WIDTH-1:0]       loss_s;

    // Zero-extend a WIDTH-bit magnitude to the sum width.
    function automatic logic [SUM_WIDTH-1:0] ext(input logic [WIDTH-1:0] v);
        ext = {{(SUM_WIDTH - WIDTH){1'b0}}, v};
    endfunction

    // Saturating post-update window count.
    always_comb begin
        count_inc_s = count_r;
        if (count_r == CNT_FULL) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Split the signed close-to-close delta into gain and loss magnitudes.
    // The low WIDTH bits of prev - price equal the magnitude of a negative delta.
    always_comb begin
        delta_s     = {1'b0, fifo_dout} - {1'b0, prev_r};
        neg_delta_s = prev_r - fifo_dout;
        gain_s      = {WIDTH{1'b0}};
        loss_s      = {WIDTH{1'b0}};
        if (delta_s[WIDTH]) begin
            loss_s = neg_delta_s;
        end else begin
            gain_s = delta_s[WIDTH-1:0];
        end
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        state_s    = state_r;
        fifo_rd_en = 1'b0;
        case (state_r)
            ST_FETCH: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_CAPTURE: begin
                // The first price after reset only primes prev.
                if (primed_r) begin
                    state_s = ST_UPDATE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_UPDATE: begin
`ifdef RSI_PARTIAL_OUT_EN
                state_s = ST_EMIT;
`else
                if (count_inc_s == CNT_FULL) begin
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_FETCH;
                end
`endif
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State register; out_valid is registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_FETCH;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == ST_EMIT);
        end
    end

    // Price capture, window buffers and running sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_r      <= 1'b0;
            prev_r        <= {WIDTH{1'b0}};
            gain_r        <= {WIDTH{1'b0}};
            loss_r        <= {WIDTH{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            gain_sum_r    <= {SUM_WIDTH{1'b0}};
            loss_sum_r    <= {SUM_WIDTH{1'b0}};
            window_full_r <= 1'b0;
            for (int i = 0; i < PERIOD; i++) begin
                gbuf_r[i] <= {WIDTH{1'b0}};
                lbuf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_CAPTURE: begin
                    prev_r   <= fifo_dout;
                    primed_r <= 1'b1;
                    if (primed_r) begin
                        gain_r <= gain_s;
                        loss_r <= loss_s;
                    end else begin
                        gain_r <= {WIDTH{1'b0}};
                        loss_r <= {WIDTH{1'b0}};
                    end
                end
                ST_UPDATE: begin
                    // The evicted entry was added earlier (or is still zero),
                    // so the subtraction can never underflow.
                    gain_sum_r    <= gain_sum_r + ext(gain_r) - ext(gbuf_r[idx_r]);
                    loss_sum_r    <= loss_sum_r + ext(loss_r) - ext(lbuf_r[idx_r]);
                    gbuf_r[idx_r] <= gain_r;
                    lbuf_r[idx_r] <= loss_r;
                    if (idx_r == IDX_LAST) begin
                        idx_r <= {IDX_W{1'b0}};
                    end else begin
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                    count_r       <= count_inc_s;
                    window_full_r <= (count_inc_s == CNT_FULL);
                end
                default: begin
                    prev_r <= prev_r;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_r;
    assign gain_sum    = gain_sum_r;
    assign loss_sum    = loss_sum_r;
    assign window_full = window_full_r;

endmodule

// File: tb/tb_rsi_delta_accum.sv
// Directed bench for rsi_delta_accum with a small array-backed FIFO model.
module tb_rsi_delta_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd_en;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [23:0] gain_sum;
    logic [23:0] loss_sum;
    logic        window_full;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] fmem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    rsi_delta_accum #(.WIDTH(16), .PERIOD(14), .SUM_WIDTH(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .gain_sum    (gain_sum),
        .loss_sum    (loss_sum),
        .window_full (window_full)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] v);
        fmem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Wait for out_valid with the FIFO drained; early counts valids seen before.
    task automatic wait_valid(input string tag, output int early);
        early = 0;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (out_valid && fifo_empty) break;
            if (out_valid) early++;
            step();
        end
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic check_sums(input string tag, input int g, input int l, input logic wf);
        check_val({tag, "_gain"}, 32'(gain_sum), 32'(g));
        check_val({tag, "_loss"}, 32'(loss_sum), 32'(l));
        check_val({tag, "_full"}, 32'(window_full), 32'(wf));
    endtask

    initial begin
        int early;
        int rd_pulses;
        int ov_cnt;

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_sums("rst", 0, 0, 1'b0);
        check_val("rst_rd_en", 32'(fifo_rd_en), 32'd0);

        // Priming price: single pop, no output
        push(16'd100);
        rd_pulses = 0;
        ov_cnt    = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (fifo_rd_en) rd_pulses++;
            if (out_valid) ov_cnt++;
            step();
        end
        check_val("prime_rd_pulses", 32'(rd_pulses), 32'd1);
        check_val("prime_no_valid", 32'(ov_cnt), 32'd0);
        check_sums("prime", 0, 0, 1'b0);

        // Ramp 101..114: fourteen deltas of +1
        for (int p = 101; p <= 114; p++) push(16'(p));
        wait_valid("ramp", early);
`ifndef RSI_PARTIAL_OUT_EN
        check_val("ramp_early_valid", 32'(early), 32'd0);
`endif
        check_sums("ramp", 14, 0, 1'b1);
        step();

        // Window slide: delta -4, oldest gain of 1 evicted
        push(16'd110);
        wait_valid("slide", early);
        check_sums("slide", 13, 4, 1'b1);
        step();

        // Backpressure: delta 0, then hold with a price waiting in the FIFO
        out_ready = 1'b0;
        push(16'd110);
        wait_valid("bp", early);
        check_sums("bp", 12, 4, 1'b1);
        push(16'd120);
        #1;
        for (int i = 0; i < 10; i++) begin
            check_val("bp_hold_valid", 32'(out_valid), 32'd1);
            check_val("bp_hold_gain", 32'(gain_sum), 32'd12);
            check_val("bp_hold_rd_en", 32'(fifo_rd_en), 32'd0);
            step();
        end
        check_val("bp_not_consumed", 32'(fifo_empty), 32'd0);
        out_ready = 1'b1;
        step();
        check_val("bp_release_valid", 32'(out_valid), 32'd0);
        check_val("bp_release_rd_en", 32'(fifo_rd_en), 32'd1);
        wait_valid("after_bp", early);
        check_sums("after_bp", 21, 4, 1'b1);
        step();

        // Extremes: 0, 65535, 0
        push(16'd0);
        wait_valid("ext0", early);
        check_sums("ext0", 20, 124, 1'b1);
        step();
        push(16'd65535);
        wait_valid("ext_max", early);
        check_sums("ext_max", 65554, 124, 1'b1);
        step();
        push(16'd0);
        wait_valid("ext_min", early);
        check_sums("ext_min", 65553, 65659, 1'b1);
        step();

        // Reset while the next price is in UPDATE
        push(16'd77);
        step();
        step();
        rst = 1'b1;
        #1;
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_sums("midrst", 0, 0, 1'b0);
        step();
        rst = 1'b0;

        // Fresh prime 50, then 55 gives a single gain of 5
        push(16'd50);
        push(16'd55);
`ifdef RSI_PARTIAL_OUT_EN
        wait_valid("partial", early);
        check_sums("partial", 5, 0, 1'b0);
        step();
`else
        ov_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid) ov_cnt++;
            step();
        end
        check_val("warmup_no_valid", 32'(ov_cnt), 32'd0);
        check_val("warmup_drained", 32'(fifo_empty), 32'd1);
        check_sums("warmup", 5, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rsi_delta_accum.md
# rsi_delta_accum

Downstream consumer of the price FIFO in the RSI pipeline. Pops one price at a time, forms the close-to-close delta against the previous price, and splits it into gain and loss magnitudes. Keeps running sums of gains and losses over a sliding window of PERIOD deltas. Presents both sums to the RSI ratio stage through a valid/ready handshake.

## Interface
- WIDTH, 16, price width in bits (unsigned), matching the FIFO data width.
- PERIOD, 14, window length in deltas; must be ≥ 2.
- SUM_WIDTH, 24, sum width in bits; must be ≥ WIDTH + ceil(log2(PERIOD)).

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  WIDTH  FIFO read data; valid the cycle after a granted read.
- fifo_rd_en  out  WIDTH=1  FIFO pop request.
- out_ready  in  1  downstream accepts the current sums.
- out_valid  out  1  gain_sum/loss_sum/window_full valid.
- gain_sum  out  SUM_WIDTH  sum of gains over the window.
- loss_sum  out  SUM_WIDTH  sum of loss magnitudes over the window.
- window_full  out  1  PERIOD deltas have been accumulated.

## Operation
- The FSM has four states: FETCH, CAPTURE, UPDATE and EMIT.
- **FETCH**
  - fifo_rd_en = !fifo_empty. This is combinational from the state and fifo_empty.
  - If fifo_rd_en is high, go to CAPTURE. Otherwise stay in FETCH.
- **CAPTURE:** register fifo_dout as the current price.
  - If primed = 0: set prev ← price and primed ← 1, then go to FETCH. This is the first price; no delta is formed.
  - Otherwise: delta = price − prev, computed as (WIDTH+1)-bit signed.
    - gain = delta > 0 ? delta : 0.
    - loss = delta < 0 ? −delta : 0.
    - Both are WIDTH bits unsigned.
    - Set prev ← price, then go to UPDATE.
- **UPDATE**
  - gain_sum ← gain_sum + gain − gbuf[idx]; loss_sum ← loss_sum + loss − lbuf[idx].
  - gbuf[idx] ← gain; lbuf[idx] ← loss.
  - idx advances with wrap from PERIOD−1 to 0.
  - count increments and saturates at PERIOD. window_full = (count == PERIOD).
  - Next state is EMIT if the post-update count is PERIOD (see Configuration); otherwise FETCH.
- **EMIT**
  - out_valid = 1. All outputs are held stable.
  - When out_ready is high, go to FETCH.
  - No FIFO read occurs while in EMIT; this is the backpressure path.
- The sums never overflow or underflow. The width rule above guarantees headroom, and the subtracted entry is always a previously added value.
- The buffers are PERIOD × WIDTH registers each.

## Timing
- **Reset values:**
  - State FETCH.
  - fifo_rd_en follows !fifo_empty.
  - out_valid 0, gain_sum 0, loss_sum 0, window_full 0.
  - primed 0, prev 0, idx 0, count 0.
  - All gbuf/lbuf entries 0.
- **Priming price:** 2 cycles from the read grant back to FETCH.
- **Subsequent prices:**
  - Read grant in cycle N.
  - Data captured at the end of N+1.
  - Sums updated at the end of N+2.
  - out_valid high from N+3.
  - Best-case throughput is 1 price per 4 cycles with out_ready held high.
- **Handshake:** transfer occurs on a cycle with out_valid and out_ready both high. out_ready is ignored outside EMIT.
- **Empty FIFO:** remain in FETCH with fifo_rd_en low indefinitely; no state changes.
- **Reset mid-operation:** an in-flight price is discarded. The next price popped after reset is treated as a priming price.

## Configuration
- The feature macro is RSI_PARTIAL_OUT_EN.
- **Defined:** EMIT is entered after every UPDATE, including warm-up. During warm-up, window_full = 0 and the sums cover count deltas.
- **Undefined:** after UPDATE, go to FETCH while count < PERIOD. out_valid is first asserted once window_full = 1.

## Test plan
- **Reset and prime:** rst pulse, then push 100.
  - One fifo_rd_en pulse; out_valid stays 0.
  - The following price of 100 produces a delta of 0.
- **Ramp 100..114 (15 prices), out_ready = 1, macro undefined:**
  - First out_valid after the 15th price.
  - gain_sum = 14, loss_sum = 0, window_full = 1.
- **Window slide:** after the ramp, push 110.
  - gain_sum = 13, loss_sum = 4.
  - The oldest gain of 1 is evicted and idx wraps.
- **Backpressure:** hold out_ready = 0 for 10 cycles with the FIFO non-empty.
  - out_valid is held and the outputs are unchanged.
  - fifo_rd_en stays 0; no price is consumed.
  - out_ready = 1 returns to FETCH on the next cycle.
- **Extremes:** prime with 0, then push 65535 and 0.
  - gain_sum ≥ 65535 and loss_sum ≥ 65535.
  - No wrap with SUM_WIDTH = 24.
- **Reset during UPDATE, then RSI_PARTIAL_OUT_EN defined:**
  - All outputs return to 0.
  - Pushing 50 then 55 gives out_valid with gain_sum = 5, loss_sum = 0, window_full = 0.
